// File: rtl/uart_loader.sv
// Boot loader behind the UART receiver: takes a 4-byte little-endian word-count header,
// then packs each following group of 4 bytes into a 32-bit word and writes it to memory.
module uart_loader #(
    parameter int unsigned ADDR_W         = 15,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_ferr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StDone,
        StErr
    } state_e;

    localparam logic [1:0] ErrNone     = 2'd0;
    localparam logic [1:0] ErrFrame    = 2'd1;
    localparam logic [1:0] ErrTimeout  = 2'd2;
    localparam logic [1:0] ErrOversize = 2'd3;

    // Largest program that fits between BASE_ADDR and the top of memory.
    localparam logic [33:0]       MaxLen   = (34'd1 << ADDR_W) - 34'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

    state_e state_q, state_d;

    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;

    logic              in_load;
    logic              frame_err;
    logic              byte_ok;
    logic              last_byte;
    logic              timeout_hit;
    logic              len_zero;
    logic              len_over;
    logic              word_last;
    logic [31:0]       assembled;
    logic [ADDR_W:0]   count_inc;

    assign in_load   = (state_q == StLen) || (state_q == StData);
    assign frame_err = rx_valid && rx_ferr;
    assign byte_ok   = rx_valid && !rx_ferr;
    assign last_byte = byte_ok && (byte_idx_q == 2'd3);

    // Bytes shift in from the top so the first byte ends up in [7:0].
    assign assembled = {rx_data, shift_q[31:8]};
    assign len_zero  = (assembled == 32'd0);
    assign len_over  = ({2'b00, assembled} > MaxLen);
    assign count_inc = word_count_q + (ADDR_W + 1)'(1);
    assign word_last = (33'(count_inc) == {1'b0, len_q});

    // A byte arriving on the limit cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !rx_valid &&
                         (tmo_q == TIMEOUT_CYCLES - 1);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StLen;
                end
            end
            StLen: begin
                if (frame_err) begin
                    state_d = StErr;
                end else if (last_byte) begin
                    if (len_zero) begin
                        state_d = StDone;
                    end else if (len_over) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end
            StData: begin
                if (frame_err) begin
                    state_d = StErr;
                end else if (last_byte) begin
                    if (word_last) begin
                        state_d = StDone;
                    end
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next-state logic
    always_comb begin
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        len_d        = len_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = done_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        word_count_d = word_count_q;
        tmo_d        = in_load ? (rx_valid ? 32'd0 : tmo_q + 32'd1) : 32'd0;
        busy_d       = (state_d == StLen) || (state_d == StData);

        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    err_code_d   = ErrNone;
                    word_count_d = '0;
                    byte_idx_d   = 2'd0;
                end
            end
            StLen: begin
                if (frame_err) begin
                    err_d      = 1'b1;
                    err_code_d = ErrFrame;
                end else if (byte_ok) begin
                    shift_d    = assembled;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (last_byte) begin
                        len_d = assembled;
                        if (len_zero) begin
                            done_d = 1'b1;
                        end else if (len_over) begin
                            err_d      = 1'b1;
                            err_code_d = ErrOversize;
                        end
                    end
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    err_code_d = ErrTimeout;
                end
            end
            StData: begin
                if (frame_err) begin
                    err_d      = 1'b1;
                    err_code_d = ErrFrame;
                end else if (byte_ok) begin
                    shift_d    = assembled;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (last_byte) begin
                        mem_we_d     = 1'b1;
                        mem_addr_d   = BaseAddr + word_count_q[ADDR_W-1:0];
                        mem_wdata_d  = assembled;
                        word_count_d = count_inc;
                        if (word_last) begin
                            done_d = 1'b1;
                        end
                    end
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    err_code_d = ErrTimeout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_idx_q   <= 2'd0;
            shift_q      <= 32'd0;
            len_q        <= 32'd0;
            tmo_q        <= 32'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ErrNone;
            word_count_q <= '0;
        end else begin
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            len_q        <= len_d;
            tmo_q        <= tmo_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            word_count_q <= word_count_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: two parameterisations share one byte stream and are each
// checked every cycle against a byte-count-level model of the loader.
module tb_uart_loader;

    localparam int unsigned TO = 50;

    logic       clk      = 1'b0;
    logic       rstn     = 1'b0;
    logic       start    = 1'b0;
    logic       rx_valid = 1'b0;
    logic       rx_ferr  = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    bit         chk_en   = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    logic        a_we, a_busy, a_done, a_err;
    logic [1:0]  a_code;
    logic [14:0] a_addr;
    logic [31:0] a_wdata;
    logic [15:0] a_wc;
    logic        b_we, b_busy, b_done, b_err;
    logic [1:0]  b_code;
    logic [3:0]  b_addr;
    logic [31:0] b_wdata;
    logic [4:0]  b_wc;

    uart_loader #(.ADDR_W(15), .BASE_ADDR(0), .TIMEOUT_CYCLES(TO)) dut_a (
        .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ferr(rx_ferr), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .busy(a_busy), .done(a_done), .err(a_err), .err_code(a_code), .word_count(a_wc)
    );

    uart_loader #(.ADDR_W(4), .BASE_ADDR(2), .TIMEOUT_CYCLES(TO)) dut_b (
        .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ferr(rx_ferr), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .busy(b_busy), .done(b_done), .err(b_err), .err_code(b_code), .word_count(b_wc)
    );

    // Model: counts bytes since start; header is bytes 0..3, every 4th byte after is a write.
    bit          m_load [2];
    bit          m_done [2];
    bit          m_err  [2];
    bit          m_we   [2];
    int unsigned m_code [2];
    int unsigned m_wc   [2];
    int unsigned m_idle [2];
    int unsigned m_nb   [2];
    logic [31:0] m_len  [2];
    logic [31:0] m_acc  [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_data [2];

    function automatic void model_reset(input int i);
        m_load[i] = 0; m_done[i] = 0; m_err[i] = 0; m_we[i] = 0;
        m_code[i] = 0; m_wc[i] = 0; m_idle[i] = 0; m_nb[i] = 0;
        m_len[i] = 0; m_acc[i] = 0; m_addr[i] = 0; m_data[i] = 0;
    endfunction

    function automatic void model_fail(input int i, input int unsigned code);
        m_err[i] = 1; m_code[i] = code; m_load[i] = 0;
    endfunction

    function automatic void model_step(input int i);
        int unsigned aw   = (i == 0) ? 15 : 4;
        int unsigned base = (i == 0) ? 0 : 2;
        m_we[i] = 0;
        if (!m_load[i]) begin
            if (start) begin
                m_load[i] = 1; m_done[i] = 0; m_err[i] = 0; m_code[i] = 0;
                m_wc[i] = 0; m_nb[i] = 0; m_idle[i] = 0;
            end
        end else if (rx_valid && rx_ferr) begin
            model_fail(i, 1);
        end else if (rx_valid) begin
            m_idle[i] = 0;
            if (m_nb[i] % 4 == 0) m_acc[i] = 0;
            m_acc[i] = m_acc[i] | (32'(rx_data) << (8 * (m_nb[i] % 4)));
            m_nb[i]++;
            if (m_nb[i] == 4) begin
                m_len[i] = m_acc[i];
                if (m_acc[i] == 0) begin
                    m_done[i] = 1; m_load[i] = 0;
                end else if ({32'b0, m_acc[i]} > ((64'd1 << aw) - 64'(base))) begin
                    model_fail(i, 3);
                end
            end else if (m_nb[i] % 4 == 0) begin
                m_we[i]   = 1;
                m_addr[i] = (base + m_wc[i]) % (32'd1 << aw);
                m_data[i] = m_acc[i];
                m_wc[i]++;
                if (m_wc[i] == m_len[i]) begin
                    m_done[i] = 1; m_load[i] = 0;
                end
            end
        end else begin
            m_idle[i]++;
            if (m_idle[i] == TO) model_fail(i, 2);
        end
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic chk(input string name, input int i, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d got=%0h exp=%0h t=%0t", name, i, got, exp, $time);
        end
    endtask

    task automatic chk_cycle(input int i, input logic [63:0] we, input logic [63:0] bsy,
                             input logic [63:0] dn, input logic [63:0] er,
                             input logic [63:0] code, input logic [63:0] wc,
                             input logic [63:0] addr, input logic [63:0] wdata);
        chk("mem_we", i, we, 64'(m_we[i]));
        chk("busy", i, bsy, 64'(m_load[i]));
        chk("done", i, dn, 64'(m_done[i]));
        chk("err", i, er, 64'(m_err[i]));
        chk("err_code", i, code, 64'(m_code[i]));
        chk("word_count", i, wc, 64'(m_wc[i]));
        if (m_we[i]) begin
            chk("mem_addr", i, addr, 64'(m_addr[i]));
            chk("mem_wdata", i, wdata, 64'(m_data[i]));
        end
    endtask

    logic [31:0] cap_a_addr[$];
    logic [31:0] cap_a_data[$];
    logic [31:0] cap_b_addr[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk_cycle(0, 64'(a_we), 64'(a_busy), 64'(a_done), 64'(a_err), 64'(a_code),
                      64'(a_wc), 64'(a_addr), 64'(a_wdata));
            chk_cycle(1, 64'(b_we), 64'(b_busy), 64'(b_done), 64'(b_err), 64'(b_code),
                      64'(b_wc), 64'(b_addr), 64'(b_wdata));
            if (a_we) begin
                cap_a_addr.push_back(32'(a_addr));
                cap_a_data.push_back(a_wdata);
            end
            if (b_we) cap_b_addr.push_back(32'(b_addr));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic f);
        rx_data = b; rx_ferr = f; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; rx_ferr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 0; k < 4; k++) begin
            send(w[8*k +: 8], 1'b0);
            if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb;
        idle(3);
        chk_en = 1'b1;
        idle(1);
        chk("reset_outputs", 0, 64'({a_we, a_busy, a_done, a_err, a_code, a_wc}), 64'd0);
        rstn = 1'b1;
        idle(2);

        // Normal load
        pulse_start();
        send(8'h02, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        send_word(32'h12345678, 1);
        send_word(32'hDEADBEEF, 0);
        chk("load_we_last", 0, 64'(a_we), 64'd1);
        chk("load_done", 0, 64'(a_done), 64'd1);
        chk("load_wc", 0, 64'(a_wc), 64'd2);
        chk("load_err", 0, 64'(a_err), 64'd0);
        idle(1);
        chk("load_nwrites", 0, 64'(cap_a_addr.size()), 64'd2);
        if (cap_a_addr.size() == 2) begin
            chk("load_addr0", 0, 64'(cap_a_addr[0]), 64'd0);
            chk("load_data0", 0, 64'(cap_a_data[0]), 64'h12345678);
            chk("load_addr1", 0, 64'(cap_a_addr[1]), 64'd1);
            chk("load_data1", 0, 64'(cap_a_data[1]), 64'hDEADBEEF);
        end

        // Empty program
        na = cap_a_addr.size();
        pulse_start();
        for (int k = 0; k < 4; k++) send(8'h00, 1'b0);
        chk("empty_done", 0, 64'(a_done), 64'd1);
        idle(1);
        chk("empty_nowrite", 0, 64'(cap_a_addr.size()), 64'(na));

        // Framing error on the 4th data byte
        pulse_start();
        send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
        chk("ferr_code", 0, 64'({a_err, a_code}), 64'h5);
        chk("ferr_busy", 0, 64'(a_busy), 64'd0);
        idle(1);
        chk("ferr_nowrite", 0, 64'(cap_a_addr.size()), 64'(na));

        // Timeout exactly TO cycles after the last byte
        pulse_start();
        send(8'hAA, 1'b0); send(8'h00, 1'b0);
        idle(TO - 1);
        chk("tmo_before", 0, 64'({a_err, a_busy}), 64'h1);
        idle(1);
        chk("tmo_at", 0, 64'({a_err, a_code}), 64'h6);

        // Byte on the limit cycle prevents the timeout
        pulse_start();
        send(8'h01, 1'b0); send(8'h00, 1'b0);
        idle(TO - 1);
        send(8'h00, 1'b0);
        chk("tmo_saved", 0, 64'(a_err), 64'd0);
        send(8'h00, 1'b0);
        send_word(32'hCAFEF00D, 0);
        chk("tmo_saved_done", 0, 64'(a_done), 64'd1);

        // Oversize on the small memory, then a full-size load at BASE_ADDR
        pulse_start();
        send(8'h0F, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        chk("oversize_b", 1, 64'({b_err, b_code}), 64'h7);
        chk("oversize_a_busy", 0, 64'(a_busy), 64'd1);
        idle(TO + 5);
        chk("oversize_a_tmo", 0, 64'(a_code), 64'd2);
        cap_b_addr.delete();
        pulse_start();
        send(8'h0E, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        for (int w = 0; w < 14; w++) send_word($urandom, 2);
        idle(2);
        chk("full_b_n", 1, 64'(cap_b_addr.size()), 64'd14);
        if (cap_b_addr.size() == 14) begin
            chk("full_b_first", 1, 64'(cap_b_addr[0]), 64'd2);
            chk("full_b_last", 1, 64'(cap_b_addr[13]), 64'd15);
        end
        chk("full_b_done", 1, 64'(b_done), 64'd1);

        // start during DATA is ignored
        pulse_start();
        send(8'h03, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        send_word(32'h01020304, 0);
        pulse_start();
        send_word(32'h05060708, 0);
        send_word(32'h090A0B0C, 0);
        chk("ign_start_done", 0, 64'({a_done, a_wc}), 64'h10003);

        // Clean restart after DONE
        pulse_start();
        chk("restart", 0, 64'({a_busy, a_done, a_wc}), 64'h20000);

        // Asynchronous reset mid-word
        send(8'h02, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        send(8'h11, 1'b0); send(8'h22, 1'b0);
        na = cap_a_addr.size();
        nb = cap_b_addr.size();
        #2 rstn = 1'b0;
        #1;
        chk("arst_a", 0, 64'({a_we, a_busy, a_done, a_err, a_code, a_wc}), 64'd0);
        chk("arst_a_addr", 0, 64'({a_addr, a_wdata}), 64'd0);
        chk("arst_b", 1, 64'({b_we, b_busy, b_done, b_err, b_code, b_wc}), 64'd0);
        idle(2);
        rstn = 1'b1;
        send(8'h33, 1'b0); send(8'h44, 1'b0);
        idle(2);
        chk("arst_nowrite_a", 0, 64'(cap_a_addr.size()), 64'(na));
        chk("arst_nowrite_b", 1, 64'(cap_b_addr.size()), 64'(nb));

        // Randomized loads: lengths, gaps, framing errors, timeouts, stray starts
        for (int it = 0; it < 30; it++) begin
            int unsigned len;
            logic [31:0] hdr;
            len = $urandom_range(0, 16);
            hdr = len;
            if ($urandom_range(0, 3) == 0) begin
                rx_data = 8'($urandom); rx_valid = 1'b1;
            end
            pulse_start();
            rx_valid = 1'b0;
            for (int k = 0; k < 4 + 4 * int'(len); k++) begin
                logic [7:0] b;
                b = (k < 4) ? hdr[8*k +: 8] : 8'($urandom);
                send(b, ($urandom_range(0, 149) == 0));
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                if ($urandom_range(0, 299) == 0) idle(TO + 5);
                if ($urandom_range(0, 99) == 0) pulse_start();
            end
            idle(TO + 5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
# uart_loader

Program loader that sits directly behind the UART receiver and sequences its byte stream into instruction-memory writes at boot. Once armed by `start`, it takes a 4-byte little-endian word-count header, then assembles each following group of 4 bytes into a 32-bit word. It writes each word to consecutive memory addresses and reports completion, or a sticky error (framing, inter-byte timeout, oversize program), to the core's boot logic.

## Interface
- `ADDR_W`, 15, word-address width of the target memory
- `BASE_ADDR`, 0, word address of the first program word
- `TIMEOUT_CYCLES`, 100_000_000, maximum idle cycles between received bytes while loading; 0 disables the timeout
- `clk`  in  1  system clock
- `rstn`  in  1  reset; asynchronous, active-low
- `start`  in  1  single-cycle arm pulse from boot logic
- `rx_data`  in  8  received byte, valid only while `rx_valid`=1
- `rx_valid`  in  1  one-cycle strobe per received byte
- `rx_ferr`  in  1  framing error flag, qualified by `rx_valid`
- `mem_we`  out  1  one-cycle memory write strobe
- `mem_addr`  out  ADDR_W  word write address
- `mem_wdata`  out  32  write data
- `busy`  out  1  high in LEN and DATA states
- `done`  out  1  sticky; load completed
- `err`  out  1  sticky; load aborted
- `err_code`  out  2  0 = none, 1 = framing, 2 = timeout, 3 = oversize
- `word_count`  out  ADDR_W+1  number of words written so far

## Operation
- States: IDLE, LEN, DATA, DONE, ERR. Reset enters IDLE, and every output resets to 0.
- `start` is honored in IDLE, DONE and ERR. On the next edge: go to LEN; clear `done`, `err`, `err_code`, `word_count`, byte index and timeout counter. `start` is ignored in LEN and DATA.
- In IDLE, DONE and ERR, `rx_valid` is ignored. If `start` and `rx_valid` arrive in the same cycle, that byte is dropped.
- LEN state:
  - Collects 4 bytes into a 32-bit length L. The first byte fills bits [7:0]; the last fills bits [31:24].
  - After the 4th byte, if L=0: go to DONE and set `done`. No writes occur.
  - If L > 2^ADDR_W − BASE_ADDR: go to ERR with code 3.
  - Otherwise go to DATA.
- DATA state:
  - Bytes are assembled little-endian into the word.
  - On the 4th byte of a word, the next edge drives `mem_we`=1, `mem_wdata`=word, `mem_addr`=BASE_ADDR+`word_count` (truncated to ADDR_W), and increments `word_count`.
  - When the incremented count equals L, the same edge enters DONE and sets `done`.
- A byte with `rx_ferr`=1 in LEN or DATA is discarded. Next edge goes to ERR with code 1, and the partial word is not written.
- Timeout:
  - In LEN and DATA, a counter increments every cycle and is cleared by each `rx_valid`.
  - When it reaches TIMEOUT_CYCLES (if nonzero), go to ERR with code 2.
  - If `rx_valid` arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the byte wins and no timeout occurs.
- ERR and DONE hold all sticky outputs until `start` or reset.
- Reset mid-load aborts immediately. Nothing further is written and all outputs return to 0.

## Timing
- All outputs are registered.
- Write latency is 1 cycle: the 4th byte's `rx_valid` at edge t gives `mem_we` high for exactly cycle t+1.
- `done` rises in the same cycle as the final `mem_we`. For L=0, `done` rises 1 cycle after the 4th header byte.
- `err` and `err_code` rise 1 cycle after the offending `rx_valid`, or 1 cycle after the counter reaches the limit.
- `busy` is high from 1 cycle after `start` until the cycle `done` or `err` rises.
- `mem_addr` and `mem_wdata` hold their last values when `mem_we`=0. Only the `mem_we` cycle is meaningful.
- Back-to-back `rx_valid` on consecutive cycles must be accepted with no loss. The UART never does this, but the bench does.

## Test plan
- Normal load (ADDR_W=15, BASE_ADDR=0):
  - Stimulus: `start`, header 02 00 00 00, then 78 56 34 12 EF BE AD DE.
  - Response: writes 0x12345678 at address 0 and 0xDEADBEEF at address 1; `done`=1 with the 2nd write; `word_count`=2; `err`=0.
- Empty program:
  - Stimulus: `start`, header 00 00 00 00.
  - Response: no `mem_we`; `done`=1 one cycle after the 4th byte.
- Framing error:
  - Stimulus: header for 1 word, then 3 bytes, then a 4th byte with `rx_ferr`=1.
  - Response: no write; `err`=1, `err_code`=1; `busy`=0.
- Timeout (TIMEOUT_CYCLES=50):
  - Stimulus: send 2 header bytes, then stop.
  - Response: `err_code`=2 exactly 50 cycles after the last byte.
  - Variant: a byte arriving on cycle 50 prevents the error.
- Oversize and BASE_ADDR (ADDR_W=4, BASE_ADDR=2):
  - Stimulus: header 0F 00 00 00.
  - Response: `err_code`=3.
  - Follow-up: after re-`start` with header 0E 00 00 00, writes go to addresses 2..15.
- Reset and restart:
  - Stimulus: assert `rstn` low mid-word; or send `start` during DATA.
  - Response: reset gives all outputs 0 immediately with no further writes; `start` during DATA is ignored; a `start` after DONE restarts cleanly with `word_count`=0.
